// File: rtl/mem_responder.sv
// Data-memory responder: serves RD/WR/psh/pop against a single-port word array
// after WAIT wait states, and owns the full-descending hardware stack pointer.
module mem_responder #(
  parameter int unsigned        ADDR_W  = 10,
  parameter int unsigned        DATA_W  = 16,
  parameter int unsigned        WAIT    = 1,
  parameter logic [ADDR_W-1:0]  SP_INIT = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              RD,
  input  logic              WR,
  input  logic              psh,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] sp,
  output logic              stk_ovf,
  output logic              stk_unf
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_WR, OP_RD, OP_PSH, OP_POP} op_t;

  localparam logic [3:0]        WAIT_LD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] SP_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              req;
  logic              accept;
  op_t               req_op;
  logic              do_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;

  always_comb begin
    req    = WR | RD | psh | pop;
    accept = (state_q == S_IDLE) && req;
    if (WR)      req_op = OP_WR;
    else if (RD) req_op = OP_RD;
    else if (psh) req_op = OP_PSH;
    else         req_op = OP_POP;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = (WAIT > 0) ? S_WAIT : S_DONE;
      S_WAIT:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // Request capture and wait counter
  always_comb begin
    op_d    = accept ? req_op : op_q;
    addr_d  = accept ? addr   : addr_q;
    wdata_d = accept ? wdata  : wdata_q;
    cnt_d   = cnt_q;
    if (accept)
      cnt_d = WAIT_LD;
    else if ((state_q == S_WAIT) && (cnt_q != '0))
      cnt_d = cnt_q - 4'd1;
  end

  // The access happens on the edge entering DONE; with WAIT=0 that is the
  // acceptance edge itself, so the *_d (bypassed) request fields are used.
  always_comb begin
    do_acc    = (state_d == S_DONE);
    mem_we    = 1'b0;
    mem_waddr = addr_d;
    rdata_d   = rdata_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (do_acc) begin
      case (op_d)
        OP_WR: mem_we = 1'b1;
        OP_RD: rdata_d = mem[addr_d];
        OP_PSH: begin
          if (sp_q == '0) begin
            ovf_d = 1'b1;
          end else begin
            sp_d      = sp_q - SP_ONE;
            mem_we    = 1'b1;
            mem_waddr = sp_q - SP_ONE;
          end
        end
        OP_POP: begin
          if (sp_q == SP_INIT) begin
            unf_d   = 1'b1;
            rdata_d = '0;
          end else begin
            rdata_d = mem[sp_q];
            sp_d    = sp_q + SP_ONE;
          end
        end
      endcase
    end
  end

  // Array contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= wdata_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= OP_WR;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      sp_q    <= SP_INIT;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
  assign sp      = sp_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT=1, WAIT=0, small stack) driven
// by directed and random requests, checked against an operation-level model.
module tb_mem_responder;

  localparam int N = 3;
  localparam logic [3:0] M_WR  = 4'b0001;
  localparam logic [3:0] M_RD  = 4'b0010;
  localparam logic [3:0] M_PSH = 4'b0100;
  localparam logic [3:0] M_POP = 4'b1000;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [9:0]  addr_i  [N];
  logic [15:0] wdata_i [N];
  logic        rd_i [N], wr_i [N], psh_i [N], pop_i [N];
  logic [15:0] rdata_o [N];
  logic        ready_o [N], busy_o [N], ovf_o [N], unf_o [N];
  logic [9:0]  sp_o [N];

  logic [15:0] m_mem   [N][1024];
  bit          m_val   [N][1024];
  int          m_sp    [N];
  bit          m_ovf   [N], m_unf [N];
  logic [15:0] m_rdata [N];
  bit          m_rknown [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(10), .DATA_W(16), .WAIT(1)) u_dut_w1 (
    .clk(clk), .reset(reset), .addr(addr_i[0]), .wdata(wdata_i[0]),
    .RD(rd_i[0]), .WR(wr_i[0]), .psh(psh_i[0]), .pop(pop_i[0]),
    .rdata(rdata_o[0]), .ready(ready_o[0]), .busy(busy_o[0]), .sp(sp_o[0]),
    .stk_ovf(ovf_o[0]), .stk_unf(unf_o[0]));

  mem_responder #(.ADDR_W(10), .DATA_W(16), .WAIT(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .addr(addr_i[1]), .wdata(wdata_i[1]),
    .RD(rd_i[1]), .WR(wr_i[1]), .psh(psh_i[1]), .pop(pop_i[1]),
    .rdata(rdata_o[1]), .ready(ready_o[1]), .busy(busy_o[1]), .sp(sp_o[1]),
    .stk_ovf(ovf_o[1]), .stk_unf(unf_o[1]));

  mem_responder #(.ADDR_W(10), .DATA_W(16), .WAIT(2), .SP_INIT(10'h003)) u_dut_small (
    .clk(clk), .reset(reset), .addr(addr_i[2]), .wdata(wdata_i[2]),
    .RD(rd_i[2]), .WR(wr_i[2]), .psh(psh_i[2]), .pop(pop_i[2]),
    .rdata(rdata_o[2]), .ready(ready_o[2]), .busy(busy_o[2]), .sp(sp_o[2]),
    .stk_ovf(ovf_o[2]), .stk_unf(unf_o[2]));

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 2;
  endfunction

  function automatic int spi_of(input int d);
    return (d == 2) ? 3 : 1023;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < N; d++) begin
      m_sp[d]     = spi_of(d);
      m_ovf[d]    = 1'b0;
      m_unf[d]    = 1'b0;
      m_rdata[d]  = '0;
      m_rknown[d] = 1'b1;
    end
  endtask

  task automatic check_regs(input int d, input string tag);
    if (m_rknown[d]) check($sformatf("%s_d%0d_rdata", tag, d), rdata_o[d], m_rdata[d]);
    check($sformatf("%s_d%0d_sp", tag, d), sp_o[d], m_sp[d]);
    check($sformatf("%s_d%0d_ovf", tag, d), ovf_o[d], m_ovf[d]);
    check($sformatf("%s_d%0d_unf", tag, d), unf_o[d], m_unf[d]);
  endtask

  // One complete handshake; lower-priority strobes in mask are also raised.
  task automatic do_op(input int d, input logic [3:0] mask, input int a, input logic [15:0] dv);
    int n;
    int nb;
    bit seen;
    if (mask[0]) begin
      m_mem[d][a] = dv;
      m_val[d][a] = 1'b1;
    end else if (mask[1]) begin
      m_rdata[d]  = m_mem[d][a];
      m_rknown[d] = m_val[d][a];
    end else if (mask[2]) begin
      if (m_sp[d] == 0) m_ovf[d] = 1'b1;
      else begin
        m_sp[d]--;
        m_mem[d][m_sp[d]] = dv;
        m_val[d][m_sp[d]] = 1'b1;
      end
    end else begin
      if (m_sp[d] == spi_of(d)) begin
        m_unf[d]    = 1'b1;
        m_rdata[d]  = '0;
        m_rknown[d] = 1'b1;
      end else begin
        m_rdata[d]  = m_mem[d][m_sp[d]];
        m_rknown[d] = m_val[d][m_sp[d]];
        m_sp[d]++;
      end
    end
    @(negedge clk);
    addr_i[d]  = 10'(a);
    wdata_i[d] = dv;
    wr_i[d]    = mask[0];
    rd_i[d]    = mask[1];
    psh_i[d]   = mask[2];
    pop_i[d]   = mask[3];
    n = 0; nb = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (busy_o[d]) nb++;
      if (ready_o[d]) seen = 1'b1;
    end
    wr_i[d] = 1'b0; rd_i[d] = 1'b0; psh_i[d] = 1'b0; pop_i[d] = 1'b0;
    check($sformatf("d%0d_ready_seen", d), 32'(seen), 1);
    check($sformatf("d%0d_latency", d), n, wait_of(d) + 1);
    check($sformatf("d%0d_busy_cycles", d), nb, wait_of(d) + 1);
    check_regs(d, "op");
    @(negedge clk);
    check($sformatf("d%0d_ready_pulse", d), 32'(ready_o[d]), 0);
    check($sformatf("d%0d_busy_idle", d), 32'(busy_o[d]), 0);
  endtask

  task automatic hold_rd(input int d, input int a);
    int cyc;
    int last;
    int cnt;
    m_rdata[d]  = m_mem[d][a];
    m_rknown[d] = m_val[d][a];
    @(negedge clk);
    addr_i[d] = 10'(a);
    rd_i[d]   = 1'b1;
    cyc = 0; last = -1; cnt = 0;
    while (cnt < 4 && cyc < 60) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (ready_o[d]) begin
        if (m_rknown[d]) check($sformatf("b2b_d%0d_rdata", d), rdata_o[d], m_rdata[d]);
        if (last >= 0) check($sformatf("b2b_d%0d_interval", d), cyc - last, wait_of(d) + 2);
        last = cyc;
        cnt++;
      end
    end
    rd_i[d] = 1'b0;
    check($sformatf("b2b_d%0d_count", d), cnt, 4);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  mask;
    int          d;
    int          a;
    for (int i = 0; i < N; i++) begin
      addr_i[i] = '0; wdata_i[i] = '0;
      rd_i[i] = 1'b0; wr_i[i] = 1'b0; psh_i[i] = 1'b0; pop_i[i] = 1'b0;
    end
    m_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_d%0d_ready", i), 32'(ready_o[i]), 0);
      check($sformatf("rst_d%0d_busy", i), 32'(busy_o[i]), 0);
      check_regs(i, "rst");
    end
    check("rst_sp_literal", sp_o[0], 10'h3FF);

    // Reset during the wait state abandons the write
    do_op(0, M_WR, 5, 16'h1111);
    @(negedge clk);
    addr_i[0] = 10'd5; wdata_i[0] = 16'hBEEF; wr_i[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wr_i[0] = 1'b0;
    m_reset();
    #1;
    check("midrst_busy", 32'(busy_o[0]), 0);
    check_regs(0, "midrst");
    @(negedge clk);
    reset = 1'b1;
    do_op(0, M_RD, 5, 16'h0);
    check("midrst_rd_literal", rdata_o[0], 16'h1111);

    // Underflow from empty stack, then a valid push/pop pair
    do_op(0, M_POP, 0, 16'h0);
    check("unf_flag_literal", 32'(unf_o[0]), 1);
    do_op(0, M_PSH, 0, 16'h0055);
    do_op(0, M_POP, 0, 16'h0);
    check("unf_sticky_literal", 32'(unf_o[0]), 1);

    // Latency, WAIT=1 and WAIT=0
    do_op(0, M_WR, 2, 16'h1234);
    do_op(0, M_RD, 2, 16'h0);
    do_op(1, M_WR, 2, 16'h1234);
    do_op(1, M_RD, 2, 16'h0);

    // LIFO
    do_op(0, M_PSH, 0, 16'h000A);
    check("lifo_sp1", sp_o[0], 10'h3FE);
    do_op(0, M_PSH, 0, 16'h000B);
    check("lifo_sp2", sp_o[0], 10'h3FD);
    do_op(0, M_PSH, 0, 16'h000C);
    check("lifo_sp3", sp_o[0], 10'h3FC);
    do_op(0, M_POP, 0, 16'h0);
    check("lifo_pop1", rdata_o[0], 16'h000C);
    do_op(0, M_POP, 0, 16'h0);
    check("lifo_pop2", rdata_o[0], 16'h000B);
    do_op(0, M_POP, 0, 16'h0);
    check("lifo_pop3", rdata_o[0], 16'h000A);
    check("lifo_sp_end", sp_o[0], 10'h3FF);
    do_op(0, M_RD, 10'h3FD, 16'h0);
    check("lifo_rd_3fd", rdata_o[0], 16'h000B);

    // Overflow on the small stack
    do_op(2, M_PSH, 0, 16'h00A1);
    do_op(2, M_PSH, 0, 16'h00A2);
    do_op(2, M_PSH, 0, 16'h00A3);
    check("ovf_pre_flag", 32'(ovf_o[2]), 0);
    do_op(2, M_PSH, 0, 16'h00A4);
    check("ovf_sp_literal", sp_o[2], 10'h000);
    check("ovf_flag_literal", 32'(ovf_o[2]), 1);
    do_op(2, M_RD, 0, 16'h0);
    check("ovf_mem0_literal", rdata_o[2], 16'h00A3);

    // Simultaneous WR and pop: only the write happens
    do_op(0, M_PSH, 0, 16'h0077);
    do_op(0, M_WR | M_POP, 9, 16'h4242);
    check("prio_sp_literal", sp_o[0], 10'h3FE);
    do_op(0, M_RD, 9, 16'h0);
    check("prio_rd_literal", rdata_o[0], 16'h4242);
    do_op(0, M_POP, 0, 16'h0);

    hold_rd(0, 2);
    hold_rd(1, 2);
    hold_rd(2, 0);

    for (int k = 0; k < 150; k++) begin
      d    = int'($urandom_range(0, 2));
      mask = 4'($urandom_range(1, 15));
      if (d == 2) a = int'($urandom_range(0, 7));
      else if ($urandom_range(0, 3) == 0) a = 1020 + int'($urandom_range(0, 3));
      else a = int'($urandom_range(0, 15));
      do_op(d, mask, a, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
